// File: rtl/mdio_pkg.sv
// Shared constants and types for the MDIO access scheduler: PHY register
// addresses, speed encoding, scheduler states and arbitration grants.
package mdio_pkg;

    localparam int unsigned REG_BMCR      = 32'd0;
    localparam int unsigned REG_BMSR      = 32'd1;
    localparam int unsigned BMSR_LINK_BIT = 32'd2;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } speed_t;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_HOST_ISSUE      = 3'd1,
        ST_HOST_WAIT       = 3'd2,
        ST_POLL_BMSR_ISSUE = 3'd3,
        ST_POLL_BMSR_WAIT  = 3'd4,
        ST_POLL_STAT_ISSUE = 3'd5,
        ST_POLL_STAT_WAIT  = 3'd6,
        ST_UPDATE          = 3'd7
    } sched_state_t;

    typedef enum logic {
        GRANT_HOST = 1'b0,
        GRANT_POLL = 1'b1
    } grant_t;

    // Reserved code 2'b11 is reported as 10M.
    function automatic speed_t decode_speed(input logic [1:0] code);
        speed_t result;
        case (code)
            2'b00:   result = SPEED_10;
            2'b01:   result = SPEED_100;
            2'b10:   result = SPEED_1000;
            default: result = SPEED_10;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running poll interval counter; raises a sticky poll_due flag at each
// expiry until the scheduler clears it.
module mdio_poll_timer #(
    parameter int unsigned POLL_INTERVAL = 1250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic poll_due
);

    localparam int unsigned CNT_W = $clog2(POLL_INTERVAL);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(POLL_INTERVAL - 32'd1);

    logic [CNT_W-1:0] count_r;
    logic             poll_due_r;
    logic             expire_s;

    assign expire_s = (count_r == LAST_COUNT);
    assign poll_due = poll_due_r;

    // Interval counter and due flag; a fresh expiry outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r    <= {CNT_W{1'b0}};
            poll_due_r <= 1'b0;
        end else if (!enable) begin
            count_r    <= {CNT_W{1'b0}};
            poll_due_r <= 1'b0;
        end else if (expire_s) begin
            count_r    <= {CNT_W{1'b0}};
            poll_due_r <= 1'b1;
        end else begin
            count_r    <= count_r + CNT_W'(1);
            poll_due_r <= poll_due_r & ~clear;
        end
    end

endmodule

// File: rtl/mdio_access_scheduler.sv
// Shares one mdio_controller between host register accesses and a periodic
// PHY link poller that publishes link_up / speed / duplex.
module mdio_access_scheduler
    import mdio_pkg::*;
#(
    parameter int unsigned PHYADDR_LENGTH = 5,
    parameter int unsigned REGADDR_LENGTH = 5,
    parameter int unsigned DATA_LENGTH    = 16,
    parameter int unsigned POLL_INTERVAL  = 1250000,
    parameter int unsigned STATUS_REG     = 17
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [PHYADDR_LENGTH-1:0] phy_address,
    input  logic                      poll_enable,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [REGADDR_LENGTH-1:0] host_reg_addr,
    input  logic [DATA_LENGTH-1:0]    host_wdata,
    output logic                      host_ack,
    output logic [DATA_LENGTH-1:0]    host_rdata,
    output logic                      mdio_read,
    output logic                      mdio_write,
    output logic [REGADDR_LENGTH-1:0] mdio_reg_address,
    output logic [DATA_LENGTH-1:0]    mdio_write_data,
    input  logic [DATA_LENGTH-1:0]    mdio_read_data,
    input  logic                      mdio_access_complete,
    input  logic                      mdio_busy,
    output logic                      link_up,
    output logic [1:0]                speed,
    output logic                      duplex,
    output logic                      link_change
);

    localparam logic [REGADDR_LENGTH-1:0] ADDR_BMCR = REGADDR_LENGTH'(REG_BMCR);
    localparam logic [REGADDR_LENGTH-1:0] ADDR_BMSR = REGADDR_LENGTH'(REG_BMSR);
    localparam logic [REGADDR_LENGTH-1:0] ADDR_STAT = REGADDR_LENGTH'(STATUS_REG);

    sched_state_t              state_r, state_s;
    grant_t                    last_grant_r, last_grant_s;
    logic                      we_r, we_s;
    logic                      mdio_read_r, mdio_read_s;
    logic                      mdio_write_r, mdio_write_s;
    logic [REGADDR_LENGTH-1:0] reg_addr_r, reg_addr_s;
    logic [DATA_LENGTH-1:0]    wdata_r, wdata_s;
    logic                      host_ack_r, host_ack_s;
    logic [DATA_LENGTH-1:0]    host_rdata_r, host_rdata_s;
    logic                      link_bit_r, link_bit_s;
    speed_t                    new_speed_r, new_speed_s;
    logic                      new_duplex_r, new_duplex_s;
    logic                      link_up_r, link_up_s;
    speed_t                    speed_r, speed_s;
    logic                      duplex_r, duplex_s;
    logic                      link_change_r, link_change_s;
    logic                      poll_clear_s;
    logic                      poll_due_s;
    logic                      unused_phy_s;

    // The PHY address is wired to the controller directly; it has no role here.
    assign unused_phy_s = ^phy_address;

    mdio_poll_timer #(
        .POLL_INTERVAL(POLL_INTERVAL)
    ) u_poll_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (poll_enable),
        .clear   (poll_clear_s),
        .poll_due(poll_due_s)
    );

    // Arbitration, request sequencing and next values of every register.
    always_comb begin
        state_s       = state_r;
        last_grant_s  = last_grant_r;
        we_s          = we_r;
        mdio_read_s   = 1'b0;
        mdio_write_s  = 1'b0;
        reg_addr_s    = reg_addr_r;
        wdata_s       = wdata_r;
        host_ack_s    = 1'b0;
        host_rdata_s  = host_rdata_r;
        link_bit_s    = link_bit_r;
        new_speed_s   = new_speed_r;
        new_duplex_s  = new_duplex_r;
        link_up_s     = link_up_r;
        speed_s       = speed_r;
        duplex_s      = duplex_r;
        link_change_s = 1'b0;
        poll_clear_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Poll takes a contested slot only if the host had the previous one.
                if (poll_due_s && (!host_req || last_grant_r == GRANT_HOST)) begin
                    state_s    = ST_POLL_BMSR_ISSUE;
                    we_s       = 1'b0;
                    reg_addr_s = ADDR_BMSR;
                end else if (host_req) begin
                    state_s    = ST_HOST_ISSUE;
                    we_s       = host_we;
                    reg_addr_s = host_reg_addr;
                    wdata_s    = host_wdata;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOST_ISSUE: begin
                if (!mdio_busy) begin
                    mdio_write_s = we_r;
                    mdio_read_s  = ~we_r;
                    state_s      = ST_HOST_WAIT;
                end else begin
                    state_s = ST_HOST_ISSUE;
                end
            end
            ST_HOST_WAIT: begin
                if (mdio_access_complete) begin
                    host_ack_s   = 1'b1;
                    host_rdata_s = we_r ? host_rdata_r : mdio_read_data;
                    last_grant_s = GRANT_HOST;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_HOST_WAIT;
                end
            end
            ST_POLL_BMSR_ISSUE: begin
                if (!mdio_busy) begin
                    mdio_read_s = 1'b1;
                    state_s     = ST_POLL_BMSR_WAIT;
                end else begin
                    state_s = ST_POLL_BMSR_ISSUE;
                end
            end
            ST_POLL_BMSR_WAIT: begin
                if (mdio_access_complete) begin
                    link_bit_s = mdio_read_data[BMSR_LINK_BIT];
                    if (mdio_read_data[BMSR_LINK_BIT]) begin
                        reg_addr_s = ADDR_STAT;
                        state_s    = ST_POLL_STAT_ISSUE;
                    end else begin
                        new_speed_s  = SPEED_10;
                        new_duplex_s = 1'b0;
                        state_s      = ST_UPDATE;
                    end
                end else begin
                    state_s = ST_POLL_BMSR_WAIT;
                end
            end
            ST_POLL_STAT_ISSUE: begin
                if (!mdio_busy) begin
                    mdio_read_s = 1'b1;
                    state_s     = ST_POLL_STAT_WAIT;
                end else begin
                    state_s = ST_POLL_STAT_ISSUE;
                end
            end
            ST_POLL_STAT_WAIT: begin
                if (mdio_access_complete) begin
                    new_speed_s  = decode_speed(mdio_read_data[15:14]);
                    new_duplex_s = mdio_read_data[13];
                    state_s      = ST_UPDATE;
                end else begin
                    state_s = ST_POLL_STAT_WAIT;
                end
            end
            ST_UPDATE: begin
                link_up_s     = link_bit_r;
                speed_s       = new_speed_r;
                duplex_s      = new_duplex_r;
                link_change_s = link_bit_r ^ link_up_r;
                last_grant_s  = GRANT_POLL;
                poll_clear_s  = 1'b1;
                state_s       = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GRANT_HOST;
            we_r          <= 1'b0;
            mdio_read_r   <= 1'b0;
            mdio_write_r  <= 1'b0;
            reg_addr_r    <= ADDR_BMCR;
            wdata_r       <= {DATA_LENGTH{1'b0}};
            host_ack_r    <= 1'b0;
            host_rdata_r  <= {DATA_LENGTH{1'b0}};
            link_bit_r    <= 1'b0;
            new_speed_r   <= SPEED_10;
            new_duplex_r  <= 1'b0;
            link_up_r     <= 1'b0;
            speed_r       <= SPEED_10;
            duplex_r      <= 1'b0;
            link_change_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            last_grant_r  <= last_grant_s;
            we_r          <= we_s;
            mdio_read_r   <= mdio_read_s;
            mdio_write_r  <= mdio_write_s;
            reg_addr_r    <= reg_addr_s;
            wdata_r       <= wdata_s;
            host_ack_r    <= host_ack_s;
            host_rdata_r  <= host_rdata_s;
            link_bit_r    <= link_bit_s;
            new_speed_r   <= new_speed_s;
            new_duplex_r  <= new_duplex_s;
            link_up_r     <= link_up_s;
            speed_r       <= speed_s;
            duplex_r      <= duplex_s;
            link_change_r <= link_change_s;
        end
    end

    assign host_ack         = host_ack_r;
    assign host_rdata       = host_rdata_r;
    assign mdio_read        = mdio_read_r;
    assign mdio_write       = mdio_write_r;
    assign mdio_reg_address = reg_addr_r;
    assign mdio_write_data  = wdata_r;
    assign link_up          = link_up_r;
    assign speed            = speed_r;
    assign duplex           = duplex_r;
    assign link_change      = link_change_r;

endmodule

// File: tb/tb_mdio_access_scheduler.sv
// Directed and randomized bench for mdio_access_scheduler with a behavioural
// PHY/controller model and a register-file reference.
module tb_mdio_access_scheduler;

    localparam int unsigned PI = 200;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  phy_address;
    logic        poll_enable;
    logic        host_req;
    logic        host_we;
    logic [4:0]  host_reg_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        mdio_read;
    logic        mdio_write;
    logic [4:0]  mdio_reg_address;
    logic [15:0] mdio_write_data;
    logic [15:0] mdio_read_data;
    logic        mdio_access_complete;
    logic        mdio_busy;
    logic        link_up;
    logic [1:0]  speed;
    logic        duplex;
    logic        link_change;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_count = 0;
    int lc_count = 0;
    int comp_cyc = 0;
    int lat      = 0;

    logic [15:0] phy_mem [32];
    logic [15:0] ref_mem [32];
    logic        log_we [$];
    logic [4:0]  log_addr [$];
    logic        p_we;
    logic [4:0]  p_addr;
    logic [15:0] p_wd;

    mdio_access_scheduler #(
        .PHYADDR_LENGTH(5),
        .REGADDR_LENGTH(5),
        .DATA_LENGTH   (16),
        .POLL_INTERVAL (PI),
        .STATUS_REG    (17)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .phy_address         (phy_address),
        .poll_enable         (poll_enable),
        .host_req            (host_req),
        .host_we             (host_we),
        .host_reg_addr       (host_reg_addr),
        .host_wdata          (host_wdata),
        .host_ack            (host_ack),
        .host_rdata          (host_rdata),
        .mdio_read           (mdio_read),
        .mdio_write          (mdio_write),
        .mdio_reg_address    (mdio_reg_address),
        .mdio_write_data     (mdio_write_data),
        .mdio_read_data      (mdio_read_data),
        .mdio_access_complete(mdio_access_complete),
        .mdio_busy           (mdio_busy),
        .link_up             (link_up),
        .speed               (speed),
        .duplex              (duplex),
        .link_change         (link_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Link status the spec's rules predict from the two PHY registers: {link, speed, duplex}.
    function automatic logic [3:0] poll_expect(input logic [15:0] bmsr, input logic [15:0] stat);
        logic [1:0] code;
        if (!bmsr[2]) return 4'b0000;
        code = stat[15:14];
        if (code == 2'd3) code = 2'd0;
        return {1'b1, code, stat[13]};
    endfunction

    // Behavioural mdio_controller + PHY: random latency, logs every request pulse.
    initial begin
        mdio_busy = 1'b0;
        mdio_access_complete = 1'b0;
        mdio_read_data = 16'h0000;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (link_change) lc_count++;
            if (!reset_n) begin
                mdio_busy = 1'b0;
                mdio_access_complete = 1'b0;
                lat = 0;
            end else begin
                if (mdio_read || mdio_write) begin
                    pulse_count++;
                    log_we.push_back(mdio_write);
                    log_addr.push_back(mdio_reg_address);
                end
                if (mdio_access_complete) begin
                    mdio_access_complete = 1'b0;
                    mdio_busy = 1'b0;
                end else if (mdio_busy) begin
                    lat--;
                    if (lat <= 0) begin
                        mdio_access_complete = 1'b1;
                        comp_cyc = cyc;
                        if (p_we) phy_mem[p_addr] = p_wd;
                        else mdio_read_data = phy_mem[p_addr];
                    end
                end else if (mdio_read || mdio_write) begin
                    mdio_busy = 1'b1;
                    lat = int'($urandom_range(2, 6));
                    p_we = mdio_write;
                    p_addr = mdio_reg_address;
                    p_wd = mdio_write_data;
                end
            end
        end
    end

    task automatic host_access(input logic we, input logic [4:0] addr, input logic [15:0] wd,
                               input bit scramble, input int exp_pulses);
        int pc0;
        int ack_cyc;
        bit got;
        logic [15:0] prev;
        logic [15:0] exp_rd;
        pc0 = pulse_count;
        prev = host_rdata;
        host_we = we;
        host_reg_addr = addr;
        host_wdata = wd;
        host_req = 1'b1;
        got = 1'b0;
        ack_cyc = 0;
        for (int i = 0; i < int'(PI) * 3 && !got; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                ack_cyc = cyc;
            end else if (scramble && i == 1) begin
                host_reg_addr = ~addr;
            end
        end
        host_req = 1'b0;
        chk("host_ack_seen", got, 1'b1);
        chk("ack_latency", ack_cyc, comp_cyc + 1);
        exp_rd = we ? prev : ref_mem[addr];
        chk("host_rdata", host_rdata, exp_rd);
        if (we) ref_mem[addr] = wd;
        else ref_mem[addr] = ref_mem[addr];
        chk("phy_reg", phy_mem[addr], ref_mem[addr]);
        chk("access_count", pulse_count - pc0, exp_pulses);
        chk("access_addr", (log_addr.size() > 0) ? log_addr[$] : ~addr, addr);
        chk("access_dir", (log_we.size() > 0) ? log_we[$] : ~we, we);
        @(negedge clk);
        chk("host_ack_pulse", host_ack, 1'b0);
        chk("host_rdata_hold", host_rdata, exp_rd);
    endtask

    task automatic wait_poll(input int nreads, input logic [3:0] exp, input logic exp_change);
        int pc0;
        int lc0;
        bit got;
        pc0 = pulse_count;
        lc0 = lc_count;
        got = 1'b0;
        for (int i = 0; i < int'(PI) * 3 && !got; i++) begin
            @(negedge clk);
            if (pulse_count >= pc0 + nreads && !mdio_busy && !mdio_access_complete) got = 1'b1;
        end
        chk("poll_done", got, 1'b1);
        @(negedge clk);
        chk("poll_status", {link_up, speed, duplex}, exp);
        chk("link_change_pulse", link_change, exp_change);
        @(negedge clk);
        chk("link_change_end", link_change, 1'b0);
        chk("poll_reads", pulse_count - pc0, nreads);
        chk("link_change_count", lc_count - lc0, exp_change);
        chk("poll_bmsr_addr", (log_addr.size() > pc0) ? log_addr[pc0] : 5'h1f, 5'd1);
        if (nreads == 2)
            chk("poll_stat_addr", (log_addr.size() > pc0 + 1) ? log_addr[pc0 + 1] : 5'h1f, 5'd17);
    endtask

    initial begin
        logic [15:0] bmsr;
        logic [15:0] stat;
        logic [3:0]  exp;
        logic        prev_link;
        logic        rwe;
        logic [4:0]  raddr;
        logic [15:0] rdat;
        int          pc5;
        bit          got;

        reset_n = 1'b0;
        phy_address = 5'h01;
        poll_enable = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        host_reg_addr = 5'd0;
        host_wdata = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            phy_mem[i] = 16'($urandom);
            ref_mem[i] = phy_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", {host_ack, host_rdata, mdio_read, mdio_write, mdio_reg_address,
                              mdio_write_data, link_up, speed, duplex, link_change}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: host write, poll disabled
        host_access(1'b1, 5'd0, 16'h1140, 1'b1, 1);
        chk("t1_reg0", phy_mem[0], 16'h1140);

        // 2: host read, link outputs untouched
        phy_mem[2] = 16'h0141;
        ref_mem[2] = 16'h0141;
        host_access(1'b0, 5'd2, 16'h0000, 1'b1, 1);
        chk("t2_rdata", host_rdata, 16'h0141);
        chk("t2_link_quiet", {link_up, speed, duplex, link_change}, 5'b00000);

        // 3: first poll with link up, 1000M full duplex
        phy_mem[1] = 16'h796D;
        phy_mem[17] = 16'hAC00;
        ref_mem[1] = 16'h796D;
        ref_mem[17] = 16'hAC00;
        poll_enable = 1'b1;
        wait_poll(2, 4'b1101, 1'b1);

        // 4: link drops, status read skipped
        phy_mem[1] = 16'h7969;
        ref_mem[1] = 16'h7969;
        wait_poll(1, 4'b0000, 1'b1);

        // random poll rounds
        prev_link = 1'b0;
        for (int r = 0; r < 5; r++) begin
            bmsr = 16'($urandom);
            stat = 16'($urandom);
            if (r == 0) bmsr[2] = 1'b1;
            phy_mem[1] = bmsr;
            phy_mem[17] = stat;
            ref_mem[1] = bmsr;
            ref_mem[17] = stat;
            exp = poll_expect(bmsr, stat);
            wait_poll(exp[3] ? 2 : 1, exp, exp[3] ^ prev_link);
            prev_link = exp[3];
        end
        poll_enable = 1'b0;
        repeat (2) @(negedge clk);

        // random host traffic
        for (int k = 0; k < 10; k++) begin
            rwe = 1'($urandom_range(0, 1));
            raddr = 5'($urandom);
            rdat = 16'($urandom);
            host_access(rwe, raddr, rdat, 1'b1, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // 5: host and poll_due collide after a host grant; poll runs first
        host_access(1'b0, 5'd3, 16'h0000, 1'b1, 1);
        phy_mem[1] = 16'h796D;
        phy_mem[17] = 16'h4000;
        ref_mem[1] = 16'h796D;
        ref_mem[17] = 16'h4000;
        @(negedge clk);
        poll_enable = 1'b1;
        repeat (PI) @(negedge clk);
        pc5 = pulse_count;
        host_access(1'b0, 5'd2, 16'h0000, 1'b0, 3);
        chk("t5_first", (log_addr.size() > pc5) ? log_addr[pc5] : 5'h1f, 5'd1);
        chk("t5_second", (log_addr.size() > pc5 + 1) ? log_addr[pc5 + 1] : 5'h1f, 5'd17);
        chk("t5_third", (log_addr.size() > pc5 + 2) ? log_addr[pc5 + 2] : 5'h1f, 5'd2);
        chk("t5_status", {link_up, speed, duplex}, 4'b1010);

        // 6: reset during HOST_WAIT, then a clean read
        poll_enable = 1'b0;
        host_we = 1'b0;
        host_reg_addr = 5'd0;
        host_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (mdio_busy) got = 1'b1;
        end
        chk("t6_in_wait", got, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {host_ack, host_rdata, mdio_read, mdio_write, mdio_reg_address,
                                 mdio_write_data, link_up, speed, duplex, link_change}, 64'd0);
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        host_access(1'b0, 5'd0, 16'h0000, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_access_scheduler.md
Name: mdio_access_scheduler

Overview:
Sits between host CSR logic and mdio_controller, and owns that controller's request interface. Shares the single MDIO master between two requesters:
- a host register-access port;
- an internal link poller that periodically reads PHY status and publishes link_up, speed and duplex to the MAC speed-select logic.

The block serialises accesses, issues single-cycle read/write pulses and collects access_complete.

Parameters:
PHYADDR_LENGTH, 5, PHY address width
REGADDR_LENGTH, 5, register address width
DATA_LENGTH, 16, MDIO data width
POLL_INTERVAL, 1250000, clk cycles between poll sequences (10 ms at 125 MHz); minimum 16
STATUS_REG, 17, PHY-specific status register address (speed at bits 15:14, duplex at bit 13)

Ports:
clk  in  1  system clock (same clock as mdio_controller)
reset_n  in  1  asynchronous, active-low reset
phy_address  in  PHYADDR_LENGTH  target PHY, used for all accesses
poll_enable  in  1  enables periodic link polling
host_req  in  1  host request; level, held until host_ack
host_we  in  1  1 = write, 0 = read; stable while host_req
host_reg_addr  in  REGADDR_LENGTH  host register address
host_wdata  in  DATA_LENGTH  host write data
host_ack  out  1  one-cycle pulse, access finished
host_rdata  out  DATA_LENGTH  read result, valid in the host_ack cycle, then held
mdio_read  out  1  to mdio_controller read
mdio_write  out  1  to mdio_controller write
mdio_reg_address  out  REGADDR_LENGTH  to mdio_controller reg_address
mdio_write_data  out  DATA_LENGTH  to mdio_controller write_data
mdio_read_data  in  DATA_LENGTH  from mdio_controller read_data
mdio_access_complete  in  1  from mdio_controller
mdio_busy  in  1  from mdio_controller busy
link_up  out  1  last polled link status (BMSR bit 2)
speed  out  2  00 = 10M, 01 = 100M, 10 = 1000M
duplex  out  1  1 = full duplex
link_change  out  1  one-cycle pulse when link_up toggles

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; poll timer and poll_due cleared; last_grant = HOST.
- FSM states:
  - IDLE, HOST_ISSUE, HOST_WAIT
  - POLL_BMSR_ISSUE, POLL_BMSR_WAIT
  - POLL_STAT_ISSUE, POLL_STAT_WAIT
  - UPDATE
- Arbitration in IDLE:
  - Only host_req: go to HOST_ISSUE.
  - Only poll_due: go to POLL_BMSR_ISSUE.
  - Both: poll wins if last_grant == HOST, else host wins. This guarantees no starvation of either side.
- *_ISSUE states:
  - Wait for mdio_busy == 0.
  - Then assert mdio_read or mdio_write for exactly one cycle, with mdio_reg_address and mdio_write_data valid that same cycle and held through WAIT.
  - Next state is the matching *_WAIT.
- *_WAIT states:
  - Ignore mdio_busy; advance only on mdio_access_complete.
  - Capture mdio_read_data on that cycle for reads.
- HOST_WAIT on complete: host_ack = 1 next cycle with host_rdata loaded (unchanged for writes). last_grant = HOST, return to IDLE.
  - host_req must drop the cycle after host_ack; a still-high host_req in IDLE is a new request.
- Poll sequence is atomic; no host grant between its two reads:
  - BMSR read: reg 1, captures bit 2.
  - If that bit is 0: skip the status read and go to UPDATE with speed = 00, duplex = 0.
  - Else: read STATUS_REG and take speed = data[15:14] and duplex = data[13]; code 11 maps to 00.
- UPDATE (1 cycle):
  - Register link_up, speed and duplex.
  - link_change = 1 the following cycle iff link_up differs from its previous value.
  - last_grant = POLL, clear poll_due, return to IDLE.
- Poll timer:
  - Counts while poll_enable = 1.
  - At POLL_INTERVAL-1 it wraps to 0 and sets poll_due.
  - Multiple expiries while poll_due is set collapse into one.
  - poll_enable = 0 clears the counter and poll_due; an in-flight poll sequence still completes and updates outputs.
- Status outputs change only in UPDATE. Host accesses never alter link_up, speed or duplex.
- Reset mid-access: FSM returns to IDLE immediately. mdio_controller shares the reset domain, so no orphaned transaction is expected.
- host_reg_addr is captured at grant; changes after grant are ignored.

Decomposition:
- Package mdio_pkg holds:
  - constants REG_BMCR = 0, REG_BMSR = 1, BMSR_LINK_BIT = 2;
  - speed enum SPEED_10/100/1000;
  - scheduler state enum;
  - grant enum HOST/POLL.
- One sub-module, mdio_poll_timer (interval counter plus poll_due flag, clear input), instantiated once.

Test Plan:
Bench: POLL_INTERVAL = 200; behavioural PHY model with phy_address 5'h01 on mdio_controller.
1. Host write reg 0 = 16'h1140, poll disabled -> one mdio_write pulse with address 0; host_ack one cycle after access_complete; PHY reg 0 = 16'h1140.
2. Host read reg 2, PHY returns 16'h0141 -> host_ack pulse with host_rdata = 16'h0141; link outputs stay 0.
3. Poll enabled, BMSR = 16'h796D, reg 17 = 16'hAC00 -> after first interval: link_up = 1, speed = 10, duplex = 1; link_change pulses once.
4. BMSR bit 2 cleared to 16'h7969 -> next poll issues only one MDIO read; link_up = 0, speed = 00, duplex = 0, link_change pulses.
5. host_req raised in the same cycle poll_due sets, last_grant = HOST -> both BMSR and STATUS_REG reads complete before the host access issues.
6. reset_n asserted during HOST_WAIT -> all outputs 0 immediately; after release, the next host read completes normally.
